execute_stage_md: RTL

- Parametrised, pipelined successor to the combinational execute stage.
- Registers its results into an EX/MEM output register with valid/ready handshakes on both sides.
- Adds an iterative RV32M-style multiply/divide unit alongside the single-cycle ALU, plus branch/jump target resolution and pipeline flush.
- Sits between the decode/ID-EX register and the memory stage.

---
 rtl/execute_stage_md.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/execute_stage_md.sv
// Pipelined execute stage: single-cycle ALU plus an iterative radix-2 multiply/divide
// unit, branch/jump target resolution and a valid/ready EX/MEM output register.
module execute_stage_md #(
    parameter int XLEN    = 32,
    parameter int REGADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    ReadData1in,
    input  logic [XLEN-1:0]    ReadData2in,
    input  logic [XLEN-1:0]    PCin,
    input  logic [XLEN-1:0]    ImmGen,
    input  logic               ALUSrc1,
    input  logic               ALUSrc2,
    input  logic [4:0]         ALUCtr,
    input  logic               Branch,
    input  logic               NotZero,
    input  logic               J_inst_ctr,
    input  logic               RegWriteIn,
    input  logic               MemReadIn,
    input  logic               MemWriteIn,
    input  logic               MemToRegIn,
    input  logic [REGADDR-1:0] WriteRegIn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    ALUOut,
    output logic               PCSrcOut,
    output logic [XLEN-1:0]    PCDataOut,
    output logic [XLEN-1:0]    ReadData2out,
    output logic               RegWriteOut,
    output logic               MemReadOut,
    output logic               MemWriteOut,
    output logic               MemToRegOut,
    output logic [REGADDR-1:0] WriteRegOut,
    output logic               busy
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MD_RUN, MD_HOLD} state_t;

    typedef struct packed {
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [REGADDR-1:0] wr_reg;
        logic [XLEN-1:0]    store_data;
        logic [XLEN-1:0]    pc_target;
    } side_t;

    state_t            state;
    logic [SHW-1:0]    md_cnt;
    logic [4:0]        md_op;
    logic              md_neg;
    logic              md_dz;
    logic [XLEN-1:0]   md_dividend;
    logic [XLEN-1:0]   md_div;
    logic [XLEN-1:0]   md_shift;
    logic [XLEN-1:0]   md_rem;
    logic [2*XLEN-1:0] md_acc;
    logic [2*XLEN-1:0] md_mcand;
    side_t             md_side;
    side_t             out_side;

    // ---------------- front end ----------------
    logic [XLEN-1:0] op_a, op_b, alu_res, pc_target;
    logic [SHW-1:0]  shamt;
    logic            is_md, accept, out_free;
    side_t           in_side;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready) && !rst;
    assign accept    = in_valid && in_ready && !flush;
    assign out_free  = !out_valid || out_ready;
    assign busy      = (state != IDLE);

    assign op_a      = ALUSrc1 ? PCin : ReadData1in;
    assign op_b      = ALUSrc2 ? ImmGen : ReadData2in;
    assign shamt     = op_b[SHW-1:0];
    assign is_md     = (ALUCtr >= 5'd10) && (ALUCtr <= 5'd16);
    assign pc_target = J_inst_ctr ? ((ReadData1in + ImmGen) & ~XLEN'(1)) : (PCin + ImmGen);

    assign in_side.reg_write  = RegWriteIn;
    assign in_side.mem_read   = MemReadIn;
    assign in_side.mem_write  = MemWriteIn;
    assign in_side.mem_to_reg = MemToRegIn;
    assign in_side.wr_reg     = WriteRegIn;
    assign in_side.store_data = ReadData2in;
    assign in_side.pc_target  = pc_target;

    always_comb begin
        alu_res = '0;
        case (ALUCtr)
            5'd0:    alu_res = op_a + op_b;
            5'd1:    alu_res = op_a - op_b;
            5'd2:    alu_res = op_a & op_b;
            5'd3:    alu_res = op_a | op_b;
            5'd4:    alu_res = op_a ^ op_b;
            5'd5:    alu_res = op_a << shamt;
            5'd6:    alu_res = op_a >> shamt;
            5'd7:    alu_res = $unsigned($signed(op_a) >>> shamt);
            5'd8:    alu_res = XLEN'($signed(op_a) < $signed(op_b));
            5'd9:    alu_res = XLEN'(op_a < op_b);
            default: alu_res = '0;
        endcase
    end

    // MD operands are always rs1/rs2; signed ops run on magnitudes and fix the sign at the end
    logic            signed_op, div_op;
    logic [XLEN-1:0] mag1, mag2;
    logic            neg_in;

    assign signed_op = (ALUCtr == 5'd11) || (ALUCtr == 5'd13) || (ALUCtr == 5'd15);
    assign div_op    = (ALUCtr >= 5'd13);
    assign mag1      = (signed_op && ReadData1in[XLEN-1]) ? -ReadData1in : ReadData1in;
    assign mag2      = (signed_op && ReadData2in[XLEN-1]) ? -ReadData2in : ReadData2in;
    assign neg_in    = (ALUCtr == 5'd15) ? ReadData1in[XLEN-1]
                     : signed_op && (ReadData1in[XLEN-1] ^ ReadData2in[XLEN-1]);

    // ---------------- iterative step ----------------
    logic              md_is_div, rem_ge, md_last;
    logic [2*XLEN-1:0] acc_nx;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_nx, shift_nx;

    assign md_is_div = (md_op >= 5'd13);
    assign md_last   = (md_cnt == SHW'(XLEN-1));

    always_comb begin
        acc_nx   = md_acc + (md_shift[0] ? md_mcand : '0);
        rem_sh   = {md_rem, md_shift[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, md_div});
        rem_nx   = rem_ge ? XLEN'(rem_sh - {1'b0, md_div}) : rem_sh[XLEN-1:0];
        shift_nx = md_is_div ? {md_shift[XLEN-2:0], rem_ge} : (md_shift >> 1);
    end

    // The final step's values are used directly so the result can load on the last edge.
    // Signed overflow falls out naturally: |min|/1 negated wraps back to min, remainder 0.
    logic [2*XLEN-1:0] fin_acc, prod;
    logic [XLEN-1:0]   fin_q, fin_r, md_result;

    always_comb begin
        fin_acc   = (state == MD_RUN) ? acc_nx   : md_acc;
        fin_q     = (state == MD_RUN) ? shift_nx : md_shift;
        fin_r     = (state == MD_RUN) ? rem_nx   : md_rem;
        prod      = md_neg ? -fin_acc : fin_acc;
        md_result = '0;
        case (md_op)
            5'd10:        md_result = prod[XLEN-1:0];
            5'd11, 5'd12: md_result = prod[2*XLEN-1:XLEN];
            5'd13, 5'd14: md_result = md_dz ? '1 : (md_neg ? -fin_q : fin_q);
            5'd15, 5'd16: md_result = md_dz ? md_dividend : (md_neg ? -fin_r : fin_r);
            default:      md_result = '0;
        endcase
    end

    logic sc_load, md_load;

    assign sc_load = accept && !is_md;
    assign md_load = (((state == MD_RUN) && md_last) || (state == MD_HOLD)) && out_free && !flush;

    // ---------------- control FSM and MD datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            md_cnt      <= '0;
            md_op       <= '0;
            md_neg      <= 1'b0;
            md_dz       <= 1'b0;
            md_dividend <= '0;
            md_div      <= '0;
            md_shift    <= '0;
            md_rem      <= '0;
            md_acc      <= '0;
            md_mcand    <= '0;
            md_side     <= '0;
        end else if (flush) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && is_md) begin
                        state       <= MD_RUN;
                        md_cnt      <= '0;
                        md_op       <= ALUCtr;
                        md_neg      <= neg_in;
                        md_dz       <= (ReadData2in == '0);
                        md_dividend <= ReadData1in;
                        md_div      <= mag2;
                        md_shift    <= div_op ? mag1 : mag2;
                        md_rem      <= '0;
                        md_acc      <= '0;
                        md_mcand    <= {{XLEN{1'b0}}, mag1};
                        md_side     <= in_side;
                    end
                end
                MD_RUN: begin
                    md_acc   <= acc_nx;
                    md_mcand <= md_mcand << 1;
                    md_shift <= shift_nx;
                    md_rem   <= rem_nx;
                    if (md_last) begin
                        md_cnt <= '0;
                        state  <= out_free ? IDLE : MD_HOLD;
                    end else begin
                        md_cnt <= md_cnt + SHW'(1);
                    end
                end
                MD_HOLD: begin
                    if (out_free) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- EX/MEM output register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ALUOut    <= '0;
            PCSrcOut  <= 1'b0;
            out_side  <= '0;
        end else begin
            if (flush)                  out_valid <= 1'b0;
            else if (sc_load || md_load) out_valid <= 1'b1;
            else if (out_ready)         out_valid <= 1'b0;

            if (sc_load) begin
                ALUOut   <= alu_res;
                PCSrcOut <= Branch && ((alu_res == '0) ^ NotZero);
                out_side <= in_side;
            end else if (md_load) begin
                ALUOut   <= md_result;
                PCSrcOut <= 1'b0;
                out_side <= md_side;
            end
        end
    end

    assign PCDataOut    = out_side.pc_target;
    assign ReadData2out = out_side.store_data;
    assign RegWriteOut  = out_side.reg_write;
    assign MemReadOut   = out_side.mem_read;
    assign MemWriteOut  = out_side.mem_write;
    assign MemToRegOut  = out_side.mem_to_reg;
    assign WriteRegOut  = out_side.wr_reg;

endmodule
